// File: rtl/adc_sync_pkg.sv
// Shared types and helpers for the multi-source ADC synchroniser/arbiter.
package adc_sync_pkg;

    // Acquisition FSM state encoding, also exported on status_state_o.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } adc_state_e;

    // Pull the channel-ID field out of a sample word (zero-extended to 16 bits).
    function automatic logic [15:0] chid_extract(input logic [63:0] word,
                                                 input int          lsb,
                                                 input int          width);
        logic [63:0] w_sh;
        logic [63:0] w_msk;
        w_sh  = word >> lsb;
        w_msk = (64'd1 << width) - 64'd1;
        return 16'(w_sh & w_msk);
    endfunction

endpackage

// File: rtl/adc_sync_edge_det.sv
// Per-source valid synchroniser: SYNC_STAGES flops, a history flop and a
// single-cycle rising-edge pulse on the synchronised strobe.
module adc_sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic i_valid_async,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    // Shift the async strobe through the synchroniser and remember last level.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_valid_async};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_edge = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/adc_sync_arb_if.sv
// Multi-source ADC synchroniser with acquisition FSM and round-robin merge.
// Each source strobe is synchronised, its sample captured on the rising edge
// into a 1-entry pending slot if accepted, and slots are drained round-robin
// into a single valid/ready output register tagged with the source index.
// Optional build macro ADC_SYNC_OVR_CNT_EN adds per-source 8-bit saturating
// overrun counters on status_ovr_cnt_o.
module adc_sync_arb_if
    import adc_sync_pkg::*;
#(
    parameter int NUM_SRC        = 2,
    parameter int ADC_DATA_WIDTH = 32,
    parameter int ADC_NUM_CHS    = 16,
    parameter int ADC_CHID_LSB   = 28,
    parameter int ADC_CHID_WIDTH = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_WIDTH      = 16,
    localparam int SW            = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                                     clk_i,
    input  logic                                     rstn_i,
    input  logic [ADC_NUM_CHS-1:0]                   cfg_ch_mask_i,
    input  logic                                     cfg_en_i,
    input  logic                                     cfg_clr_i,
    input  logic                                     cfg_arm_i,
    input  logic [SW-1:0]                            cfg_trig_src_i,
    input  logic [ADC_CHID_WIDTH-1:0]                cfg_trig_chid_i,
    input  logic                                     cfg_limit_en_i,
    input  logic [CNT_WIDTH-1:0]                     cfg_num_samples_i,
    input  logic [NUM_SRC-1:0]                       adc_valid_async_i,
    input  logic [NUM_SRC-1:0][ADC_DATA_WIDTH-1:0]   adc_data_async_i,
    output logic                                     out_valid_o,
    input  logic                                     out_ready_i,
    output logic [ADC_DATA_WIDTH-1:0]                out_data_o,
    output logic [SW-1:0]                            out_src_o,
    output logic [1:0]                               status_state_o,
    output logic                                     status_done_o,
    output logic [NUM_SRC-1:0]                       status_ovr_o,
    input  logic                                     ovr_clr_i
`ifdef ADC_SYNC_OVR_CNT_EN
    ,
    output logic [NUM_SRC-1:0][7:0]                  status_ovr_cnt_o
`endif
);

    logic [NUM_SRC-1:0]                     w_edge;
    logic [NUM_SRC-1:0][15:0]               w_chid;
    logic [NUM_SRC-1:0]                     w_mask_ok;
    logic [NUM_SRC-1:0]                     w_trig_hit;
    logic [NUM_SRC-1:0]                     w_elig;
    logic [NUM_SRC-1:0]                     w_acc;
    logic [NUM_SRC-1:0]                     w_ovr_set;
    logic                                   w_trig;
    logic                                   w_lim_act;
    logic                                   w_hit;
    logic [CNT_WIDTH-1:0]                   w_cnt_nxt;
    logic [CNT_WIDTH-1:0]                   r_cnt;
    adc_state_e                             r_state;
    adc_state_e                             w_state_nxt;
    logic [NUM_SRC-1:0]                     r_pend;
    logic [NUM_SRC-1:0][ADC_DATA_WIDTH-1:0] r_pend_data;
    logic [SW-1:0]                          r_last;
    logic [SW-1:0]                          w_gnt;
    logic                                   w_gnt_vld;
    logic                                   w_load;

    // One synchroniser/edge detector per source; chid taken from the raw word,
    // which is stable across the capture edge.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        adc_sync_edge_det #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_edge (
            .clk_i         (clk_i),
            .rstn_i        (rstn_i),
            .i_valid_async (adc_valid_async_i[g]),
            .o_edge        (w_edge[g])
        );
        assign w_chid[g] = chid_extract(64'(adc_data_async_i[g]), ADC_CHID_LSB, ADC_CHID_WIDTH);
    end

    // Channel mask lookup; chids outside the mask range never match and are rejected.
    always_comb begin
        w_mask_ok = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int c = 0; c < ADC_NUM_CHS; c++) begin
                if (w_chid[s] == 16'(c)) w_mask_ok[s] = cfg_ch_mask_i[c];
            end
        end
    end

    // Trigger detection and eligibility: in ARMED only the trigger sample itself may pass.
    always_comb begin
        w_trig_hit = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            w_trig_hit[s] = (r_state == ST_ARMED) && w_edge[s] &&
                            (cfg_trig_src_i == SW'(s)) &&
                            (w_chid[s] == 16'(cfg_trig_chid_i));
        end
        w_trig = |w_trig_hit;
        if (r_state == ST_RUN) w_elig = w_edge & w_mask_ok;
        else                   w_elig = w_trig_hit & w_mask_ok;
    end

    assign w_lim_act = cfg_limit_en_i && (cfg_num_samples_i != '0);

    // Count accepts lowest index first; anything past the limit is dropped.
    always_comb begin
        w_acc     = '0;
        w_cnt_nxt = r_cnt;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (w_elig[s] && !cfg_clr_i && !(w_lim_act && (w_cnt_nxt >= cfg_num_samples_i))) begin
                w_acc[s]  = 1'b1;
                w_cnt_nxt = w_cnt_nxt + CNT_WIDTH'(1);
            end
        end
        w_hit = w_lim_act && (|w_acc) && (w_cnt_nxt >= cfg_num_samples_i);
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // FSM next state and status outputs; clear beats everything.
    always_comb begin
        w_state_nxt    = r_state;
        status_state_o = r_state;
        status_done_o  = (r_state == ST_DONE);
        if (cfg_clr_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (cfg_en_i) w_state_nxt = cfg_arm_i ? ST_ARMED : ST_RUN;
                ST_ARMED: if (w_hit) w_state_nxt = ST_DONE;
                          else if (w_trig) w_state_nxt = ST_RUN;
                ST_RUN:   if (w_hit) w_state_nxt = ST_DONE;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    // Accepted-sample counter, zeroed on start and on clear.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)                                      r_cnt <= '0;
        else if (cfg_clr_i || (r_state == ST_IDLE && cfg_en_i)) r_cnt <= '0;
        else                                              r_cnt <= w_cnt_nxt;
    end

    // Round-robin pick: first pending source after the last granted one.
    always_comb begin
        int idx;
        idx       = 0;
        w_gnt     = r_last;
        w_gnt_vld = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(r_last) + k) % NUM_SRC;
            if (!w_gnt_vld && r_pend[idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = SW'(idx);
            end
        end
    end

    assign w_load = w_gnt_vld && (!out_valid_o || out_ready_i) && !cfg_clr_i;

    // Overwrite of a slot that is not leaving this cycle is an overrun.
    always_comb begin
        w_ovr_set = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            w_ovr_set[s] = w_acc[s] && r_pend[s] && !(w_load && (w_gnt == SW'(s)));
        end
    end

    // Pending slots: new accept wins over the slot being drained.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_pend      <= '0;
            r_pend_data <= '0;
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (cfg_clr_i) begin
                    r_pend[s] <= 1'b0;
                end else if (w_acc[s]) begin
                    r_pend[s]      <= 1'b1;
                    r_pend_data[s] <= adc_data_async_i[s];
                end else if (w_load && (w_gnt == SW'(s))) begin
                    r_pend[s] <= 1'b0;
                end
            end
        end
    end

    // Output register: holds while stalled, reloads on ready, dropped by clear.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_src_o   <= '0;
            r_last      <= SW'(NUM_SRC - 1);
        end else if (cfg_clr_i) begin
            out_valid_o <= 1'b0;
        end else if (w_load) begin
            out_valid_o <= 1'b1;
            out_data_o  <= r_pend_data[w_gnt];
            out_src_o   <= w_gnt;
            r_last      <= w_gnt;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

`ifdef ADC_SYNC_OVR_CNT_EN
    logic [NUM_SRC-1:0][7:0] r_ovr_cnt;

    // Saturating per-source overrun counters; a set in the clear cycle leaves 1.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ovr_cnt <= '0;
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (w_ovr_set[s]) begin
                    if (ovr_clr_i)                 r_ovr_cnt[s] <= 8'd1;
                    else if (r_ovr_cnt[s] != 8'hFF) r_ovr_cnt[s] <= r_ovr_cnt[s] + 8'd1;
                end else if (ovr_clr_i) begin
                    r_ovr_cnt[s] <= 8'd0;
                end
            end
        end
    end

    // Sticky flag view of the counters.
    always_comb begin
        status_ovr_o = '0;
        for (int s = 0; s < NUM_SRC; s++) status_ovr_o[s] = |r_ovr_cnt[s];
    end

    assign status_ovr_cnt_o = r_ovr_cnt;
`else
    logic [NUM_SRC-1:0] r_ovr;

    // Sticky per-source overrun flags; a set in the clear cycle wins.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_ovr <= '0;
        else         r_ovr <= (ovr_clr_i ? '0 : r_ovr) | w_ovr_set;
    end

    assign status_ovr_o = r_ovr;
`endif

endmodule

// File: tb/tb_adc_sync_arb_if.sv
// Directed self-checking bench for adc_sync_arb_if (NUM_SRC=2, SYNC_STAGES=2).
module tb_adc_sync_arb_if;

    logic                  clk_i = 1'b0;
    logic                  rstn_i = 1'b0;
    logic [15:0]           cfg_ch_mask_i = '0;
    logic                  cfg_en_i = 1'b0;
    logic                  cfg_clr_i = 1'b0;
    logic                  cfg_arm_i = 1'b0;
    logic [0:0]            cfg_trig_src_i = '0;
    logic [3:0]            cfg_trig_chid_i = '0;
    logic                  cfg_limit_en_i = 1'b0;
    logic [15:0]           cfg_num_samples_i = '0;
    logic [1:0]            adc_valid_async_i = '0;
    logic [1:0][31:0]      adc_data_async_i = '0;
    logic                  out_valid_o;
    logic                  out_ready_i = 1'b1;
    logic [31:0]           out_data_o;
    logic [0:0]            out_src_o;
    logic [1:0]            status_state_o;
    logic                  status_done_o;
    logic [1:0]            status_ovr_o;
    logic                  ovr_clr_i = 1'b0;
`ifdef ADC_SYNC_OVR_CNT_EN
    logic [1:0][7:0]       status_ovr_cnt_o;
`endif

    int total = 0;
    int bad   = 0;
    logic [32:0] q[$];

    adc_sync_arb_if dut (
        .clk_i             (clk_i),
        .rstn_i            (rstn_i),
        .cfg_ch_mask_i     (cfg_ch_mask_i),
        .cfg_en_i          (cfg_en_i),
        .cfg_clr_i         (cfg_clr_i),
        .cfg_arm_i         (cfg_arm_i),
        .cfg_trig_src_i    (cfg_trig_src_i),
        .cfg_trig_chid_i   (cfg_trig_chid_i),
        .cfg_limit_en_i    (cfg_limit_en_i),
        .cfg_num_samples_i (cfg_num_samples_i),
        .adc_valid_async_i (adc_valid_async_i),
        .adc_data_async_i  (adc_data_async_i),
        .out_valid_o       (out_valid_o),
        .out_ready_i       (out_ready_i),
        .out_data_o        (out_data_o),
        .out_src_o         (out_src_o),
        .status_state_o    (status_state_o),
        .status_done_o     (status_done_o),
        .status_ovr_o      (status_ovr_o),
        .ovr_clr_i         (ovr_clr_i)
`ifdef ADC_SYNC_OVR_CNT_EN
        ,
        .status_ovr_cnt_o  (status_ovr_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Record every completed output transfer as {src, data}.
    always @(negedge clk_i) begin
        if (rstn_i && out_valid_o && out_ready_i) q.push_back({out_src_o, out_data_o});
    end

    function automatic logic [31:0] mk(input logic [3:0] chid, input logic [27:0] pl);
        return {chid, pl};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // One strobe: valid high over two edges, then low long enough to re-arm.
    task automatic send(input int s, input logic [3:0] chid, input logic [27:0] pl);
        @(negedge clk_i);
        adc_data_async_i[s]  = mk(chid, pl);
        adc_valid_async_i[s] = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        adc_valid_async_i[s] = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic pulse_en();
        @(negedge clk_i); cfg_en_i = 1'b1;
        @(negedge clk_i); cfg_en_i = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk_i); cfg_clr_i = 1'b1;
        @(negedge clk_i); cfg_clr_i = 1'b0;
    endtask

    initial begin
        // Reset values
        idle(3);
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_data",  64'(out_data_o), 64'd0);
        chk("rst_src",   64'(out_src_o), 64'd0);
        chk("rst_state", 64'(status_state_o), 64'd0);
        chk("rst_done",  64'(status_done_o), 64'd0);
        chk("rst_ovr",   64'(status_ovr_o), 64'd0);
        @(negedge clk_i); rstn_i = 1'b1;
        idle(2);

        // Continuous, all channels, src0 chids 0..9, latency check on the first
        cfg_ch_mask_i = 16'hFFFF;
        pulse_en();
        chk("t1_state_run", 64'(status_state_o), 64'd2);
        @(negedge clk_i);
        adc_data_async_i[0]  = mk(4'd0, 28'h0000A00);
        adc_valid_async_i[0] = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i); adc_valid_async_i[0] = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i); #1 chk("t1_lat_k2", 64'(out_valid_o), 64'd0);
        @(posedge clk_i); #1 chk("t1_lat_k3", 64'(out_valid_o), 64'd1);
        for (int i = 1; i < 10; i++) send(0, 4'(i), 28'h0000A00 + 28'(i));
        idle(6);
        chk("t1_count", 64'(q.size()), 64'd10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("t1_out%0d", i), 64'(q[i]), 64'({1'b0, mk(4'(i), 28'h0000A00 + 28'(i))}));
        pulse_clr();
        chk("t1_clr_idle", 64'(status_state_o), 64'd0);
        q.delete();

        // Mask 0x0005: only chids 0 and 2 pass
        cfg_ch_mask_i = 16'h0005;
        pulse_en();
        for (int i = 0; i < 4; i++) send(0, 4'(i), 28'h0000B00 + 28'(i));
        idle(6);
        chk("t2_count", 64'(q.size()), 64'd2);
        chk("t2_out0", 64'(q[0]), 64'({1'b0, 32'h00000B00}));
        chk("t2_out1", 64'(q[1]), 64'({1'b0, 32'h20000B02}));
        pulse_clr();
        q.delete();

        // Armed on src1 chid3
        cfg_ch_mask_i   = 16'hFFFF;
        cfg_arm_i       = 1'b1;
        cfg_trig_src_i  = 1'b1;
        cfg_trig_chid_i = 4'd3;
        pulse_en();
        chk("t3_armed", 64'(status_state_o), 64'd1);
        send(1, 4'd1, 28'h0000C01);
        send(1, 4'd2, 28'h0000C02);
        chk("t3_still_armed", 64'(status_state_o), 64'd1);
        send(1, 4'd3, 28'h0000C03);
        chk("t3_run", 64'(status_state_o), 64'd2);
        send(1, 4'd4, 28'h0000C04);
        idle(6);
        chk("t3_count", 64'(q.size()), 64'd2);
        chk("t3_out0", 64'(q[0]), 64'({1'b1, 32'h30000C03}));
        chk("t3_out1", 64'(q[1]), 64'({1'b1, 32'h40000C04}));
        pulse_clr();
        cfg_arm_i = 1'b0;
        q.delete();

        // Limit 4 across two sources
        cfg_limit_en_i    = 1'b1;
        cfg_num_samples_i = 16'd4;
        pulse_en();
        send(0, 4'd0, 28'h0000D00);
        send(1, 4'd1, 28'h0000D01);
        send(0, 4'd2, 28'h0000D02);
        chk("t4_run_before_limit", 64'(status_state_o), 64'd2);
        send(1, 4'd3, 28'h0000D03);
        chk("t4_done_state", 64'(status_state_o), 64'd3);
        chk("t4_done_flag", 64'(status_done_o), 64'd1);
        send(0, 4'd4, 28'h0000D04);
        send(1, 4'd5, 28'h0000D05);
        pulse_en();
        chk("t4_en_ignored", 64'(status_state_o), 64'd3);
        idle(4);
        chk("t4_count", 64'(q.size()), 64'd4);
        chk("t4_out0", 64'(q[0]), 64'({1'b0, 32'h00000D00}));
        chk("t4_out1", 64'(q[1]), 64'({1'b1, 32'h10000D01}));
        chk("t4_out2", 64'(q[2]), 64'({1'b0, 32'h20000D02}));
        chk("t4_out3", 64'(q[3]), 64'({1'b1, 32'h30000D03}));
        pulse_clr();
        chk("t4_clr_state", 64'(status_state_o), 64'd0);
        chk("t4_clr_done", 64'(status_done_o), 64'd0);
        cfg_limit_en_i = 1'b0;
        q.delete();

        // Overrun: output stalled by src1, two src0 samples collide in the slot
        pulse_en();
        @(negedge clk_i); out_ready_i = 1'b0;
        send(1, 4'd5, 28'h0000E05);
        send(0, 4'd6, 28'h0000E06);
        chk("t5_no_ovr_yet", 64'(status_ovr_o), 64'd0);
        send(0, 4'd7, 28'h0000E07);
        chk("t5_ovr", 64'(status_ovr_o), 64'd1);
`ifdef ADC_SYNC_OVR_CNT_EN
        chk("t5_ovr_cnt", 64'(status_ovr_cnt_o[0]), 64'd1);
`endif
        chk("t5_hold_valid", 64'(out_valid_o), 64'd1);
        chk("t5_hold_data", 64'(out_data_o), 64'h50000E05);
        chk("t5_hold_src", 64'(out_src_o), 64'd1);
        @(negedge clk_i); out_ready_i = 1'b1;
        idle(4);
        chk("t5_count", 64'(q.size()), 64'd2);
        chk("t5_out0", 64'(q[0]), 64'({1'b1, 32'h50000E05}));
        chk("t5_out1", 64'(q[1]), 64'({1'b0, 32'h70000E07}));
        @(negedge clk_i); ovr_clr_i = 1'b1;
        @(negedge clk_i); ovr_clr_i = 1'b0;
        chk("t5_ovr_clr", 64'(status_ovr_o), 64'd0);
        q.delete();

        // Clear while output valid and src1 pending
        @(negedge clk_i); out_ready_i = 1'b0;
        send(0, 4'd8, 28'h0000F08);
        send(1, 4'd9, 28'h0000F09);
        chk("t6_valid_before", 64'(out_valid_o), 64'd1);
        @(negedge clk_i); cfg_clr_i = 1'b1;
        @(posedge clk_i); #1;
        chk("t6_valid_dropped", 64'(out_valid_o), 64'd0);
        chk("t6_idle", 64'(status_state_o), 64'd0);
        @(negedge clk_i); cfg_clr_i = 1'b0; out_ready_i = 1'b1;
        idle(6);
        chk("t6_no_outputs", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
